uart_tx_arbiter: RTL and testbench

Round-robin scheduler sharing one uart transmitter between NUM_REQ byte-producing clients. Each client presents a byte with a req/ack handshake. The block drives the uart's ld_tx_data/tx_data/tx_enable and tracks tx_empty to sequence one byte at a time. It inserts a programmable idle gap between bytes and flags a uart that fails to accept a load.

---
 rtl/uart_tx_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart transmitter between NUM_REQ
// byte-producing clients. Sequences one byte at a time (load, wait for the uart to go
// busy, wait for it to drain, idle gap) and flags a uart that never accepts a load.
// Optional feature macro: UART_ARB_LOCK_EN adds a per-client lock input that keeps the
// grant on the same client across consecutive bytes of a frame.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned GAP_CYCLES   = 1,
  parameter int unsigned BUSY_TIMEOUT = 3
) (
  input  logic                 txclk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 ld_tx_data,
  output logic [7:0]           tx_data,
  output logic                 tx_enable,
  input  logic                 tx_empty,
  output logic                 busy,
  output logic                 err,
  input  logic                 clr_err
`ifdef UART_ARB_LOCK_EN
  ,
  input  logic [NUM_REQ-1:0]   lock
`endif
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // Width floors at 1 so a zero gap still gets a legal (unused) counter.
  localparam int unsigned GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int unsigned ToW  = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [GapW-1:0] GapLoad = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [ToW-1:0]  ToLast  = ToW'(BUSY_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWaitBusy,
    StWaitDone,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [7:0]        data_q, data_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [ToW-1:0]    to_q, to_d;
  logic              err_q, err_d;

  logic              rr_found;
  logic [IdxW-1:0]   rr_idx;
  logic [IdxW-1:0]   cand_idx;
  int unsigned       cand;
  logic              timeout;
  logic              byte_done;
  logic              relock;

  // Round-robin pick: first set request scanning upward from last_winner + 1.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_q;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IdxW'(cand);
      if (!rr_found && req[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // A locked client still requesting keeps the uart without re-arbitration.
`ifdef UART_ARB_LOCK_EN
  assign relock = lock[win_q] && req[win_q];
`else
  assign relock = 1'b0;
`endif

  // Next-state logic for the transfer sequencer and the sticky error flag.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    win_d     = win_q;
    last_d    = last_q;
    data_d    = data_q;
    gap_d     = gap_q;
    to_d      = to_q;
    err_d     = err_q;
    timeout   = 1'b0;
    byte_done = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (rr_found && tx_empty) begin
          grant_d = NUM_REQ'(1) << rr_idx;
          win_d   = rr_idx;
          data_d  = req_data[{rr_idx, 3'b000} +: 8];
          state_d = StLoad;
        end
      end
      StLoad: begin
        last_d  = win_q;
        to_d    = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (!tx_empty) begin
          state_d = StWaitDone;
        end else if (to_q == ToLast) begin
          timeout = 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StWaitDone: begin
        if (tx_empty) begin
          if (GAP_CYCLES == 0) begin
            byte_done = 1'b1;
          end else begin
            gap_d   = GapLoad;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == '0) byte_done = 1'b1;
        else gap_d = gap_q - 1'b1;
      end
      default: state_d = StIdle;
    endcase

    if (byte_done) begin
      if (relock) begin
        data_d  = req_data[{win_q, 3'b000} +: 8];
        state_d = StLoad;
      end else begin
        grant_d = '0;
        state_d = StIdle;
      end
    end

    // A new timeout wins over a simultaneous clear.
    if (timeout) err_d = 1'b1;
    else if (clr_err) err_d = 1'b0;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      win_q   <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      data_q  <= '0;
      gap_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      win_q   <= win_d;
      last_q  <= last_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
      to_q    <= to_d;
      err_q   <= err_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    ld_tx_data = (state_q == StLoad);
    ack        = (state_q == StLoad) ? grant_q : '0;
    tx_enable  = (state_q == StLoad) || (state_q == StWaitBusy) || (state_q == StWaitDone);
    busy       = (state_q != StIdle);
    grant      = grant_q;
    tx_data    = data_q;
    err        = err_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a small behavioural uart model.
// Build with UART_ARB_LOCK_EN defined to exercise the lock variant.
module tb_uart_tx_arbiter;

  localparam int GAP = 1;

  logic        txclk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [3:0]  grant;
  logic        ld_tx_data;
  logic [7:0]  tx_data;
  logic        tx_enable;
  logic        tx_empty;
  logic        busy;
  logic        err;
  logic        clr_err;
`ifdef UART_ARB_LOCK_EN
  logic [3:0]  lock;
`endif

  uart_tx_arbiter #(
    .NUM_REQ      (4),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (3)
  ) dut (
    .txclk      (txclk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .grant      (grant),
    .ld_tx_data (ld_tx_data),
    .tx_data    (tx_data),
    .tx_enable  (tx_enable),
    .tx_empty   (tx_empty),
    .busy       (busy),
    .err        (err),
    .clr_err    (clr_err)
`ifdef UART_ARB_LOCK_EN
    ,
    .lock       (lock)
`endif
  );

  initial txclk = 1'b0;
  always #5 txclk = ~txclk;

  int checks = 0;
  int errors = 0;
  int proto_viol = 0;
  int drop_viol = 0;
  bit stuck = 1'b0;

  logic [7:0] serial_q[$];
  int         exp_order[$];
  int         got_order[$];
  int         rem[4];

  typedef struct packed {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[5];

  // Uart model: load when empty, then start, 8 data bits LSB first, stop.
  logic [3:0] bitn;
  logic [7:0] sh;
  logic [7:0] rx;
  always @(posedge txclk) begin
    if (!reset_n) begin
      tx_empty <= 1'b1;
      bitn     <= '0;
    end else if (tx_empty) begin
      if (ld_tx_data && !stuck) begin
        tx_empty <= 1'b0;
        sh       <= tx_data;
        bitn     <= '0;
      end
    end else if (!tx_enable) begin
      drop_viol <= drop_viol + 1;
    end else begin
      if (bitn >= 4'd1 && bitn <= 4'd8) begin
        rx <= {sh[0], rx[7:1]};
        sh <= {1'b0, sh[7:1]};
      end
      if (bitn == 4'd9) begin
        serial_q.push_back(rx);
        tx_empty <= 1'b1;
        bitn     <= '0;
      end else begin
        bitn <= bitn + 4'd1;
      end
    end
  end

  // Handshake protocol monitor.
  always @(negedge txclk) begin
    if (reset_n) begin
      if ((ack & ~grant) != 4'd0 || $countones(ack) > 1 || (ld_tx_data != (|ack)))
        proto_viol <= proto_viol + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] base(input int i);
    return 8'(17 * (i + 1));
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    clr_err = 1'b0;
    stuck   = 1'b0;
    repeat (2) @(negedge txclk);
    reset_n = 1'b1;
  endtask

  // Wait for the next load strobe; returns cycles waited.
  task automatic wait_ld(output int lat);
    lat = 0;
    do begin
      @(negedge txclk);
      lat++;
    end while (!ld_tx_data && lat < 20);
  endtask

  task automatic do_vector(input vec_t v, input string tag);
    int lat;
    int gap;
    int n;
    serial_q.delete();
    req_data = v.data;
    req      = v.req;
    wait_ld(lat);
    check({tag, "_lat"}, 32'(lat), 32'd1);
    check({tag, "_ack"}, 32'(ack), 32'(v.ack));
    check({tag, "_grant"}, 32'(grant), 32'(v.ack));
    check({tag, "_txdata"}, 32'(tx_data), 32'(v.exp_byte));
    req = '0;
    gap = 0;
    n   = 0;
    do begin
      @(negedge txclk);
      n++;
      if (busy && !tx_enable) gap++;
    end while (busy && n < 60);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_gap"}, 32'(gap), 32'(GAP));
    check({tag, "_nser"}, 32'(serial_q.size()), 32'd1);
    if (serial_q.size() > 0) check({tag, "_ser"}, 32'(serial_q[0]), 32'(v.exp_byte));
  endtask

  // Drive req per rem[], collect ack order and serial bytes, compare to exp_order.
  task automatic run_seq(input logic [3:0] mask, input string tag);
    int sent[4];
    int occ[4];
    int got;
    int budget;
    int idx;
    logic [7:0] eb;
    for (int i = 0; i < 4; i++) begin
      sent[i] = 0;
      occ[i]  = 0;
      req_data[8*i +: 8] = base(i);
    end
    got_order.delete();
    serial_q.delete();
    got    = 0;
    budget = 0;
    req    = mask;
    while (got < exp_order.size() && budget < 400) begin
      @(negedge txclk);
      budget++;
      if (ack != 4'd0) begin
        idx = onehot_idx(ack);
        got_order.push_back(idx);
        got++;
        sent[idx]++;
        if (sent[idx] >= rem[idx]) req[idx] = 1'b0;
        else req_data[8*idx +: 8] = 8'(base(idx) + 8'(64 * sent[idx]));
      end
    end
    req    = '0;
    budget = 0;
    do begin
      @(negedge txclk);
      budget++;
    end while (busy && budget < 60);
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_nack"}, 32'(got), 32'(exp_order.size()));
    check({tag, "_nser"}, 32'(serial_q.size()), 32'(exp_order.size()));
    for (int k = 0; k < exp_order.size() && k < got_order.size(); k++) begin
      check($sformatf("%s_order%0d", tag, k), 32'(got_order[k]), 32'(exp_order[k]));
      eb = 8'(base(exp_order[k]) + 8'(64 * occ[exp_order[k]]));
      occ[exp_order[k]]++;
      if (k < serial_q.size()) check($sformatf("%s_byte%0d", tag, k), 32'(serial_q[k]), 32'(eb));
    end
  endtask

  initial begin
    int lat;
    vecs[0] = '{req: 4'b0001, data: 32'h0000_00A5, ack: 4'b0001, exp_byte: 8'hA5};
    vecs[1] = '{req: 4'b0010, data: 32'h0000_3C00, ack: 4'b0010, exp_byte: 8'h3C};
    vecs[2] = '{req: 4'b1000, data: 32'h8100_0000, ack: 4'b1000, exp_byte: 8'h81};
    vecs[3] = '{req: 4'b0100, data: 32'h00FF_0000, ack: 4'b0100, exp_byte: 8'hFF};
    vecs[4] = '{req: 4'b0001, data: 32'h0000_0000, ack: 4'b0001, exp_byte: 8'h00};

    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;
    clr_err  = 1'b0;
`ifdef UART_ARB_LOCK_EN
    lock     = '0;
`endif
    repeat (3) @(negedge txclk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_ld", 32'(ld_tx_data), 32'd0);
    check("rst_txdata", 32'(tx_data), 32'd0);
    check("rst_txen", 32'(tx_enable), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    reset_n = 1'b1;
    @(negedge txclk);
    check("idle_noreq_busy", 32'(busy), 32'd0);

    // Single-client transfers.
    for (int i = 0; i < 5; i++) do_vector(vecs[i], $sformatf("vec%0d", i));

    // All four requesting at once.
    do_reset();
    rem = '{1, 1, 1, 1};
    exp_order = '{0, 1, 2, 3};
    run_seq(4'b1111, "all4");

    // Fairness: wrap past the pointer.
    do_reset();
    rem = '{0, 0, 1, 0};
    exp_order = '{2};
    run_seq(4'b0100, "fair_a");
    rem = '{1, 0, 1, 0};
    exp_order = '{0, 2};
    run_seq(4'b0101, "fair_b");

    // Load timeout: uart never leaves empty.
    stuck    = 1'b1;
    req_data = 32'h0000_005A;
    req      = 4'b0001;
    wait_ld(lat);
    check("to1_lat", 32'(lat), 32'd1);
    req = '0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge txclk);
      check($sformatf("to1_wb%0d", k), 32'({busy, err, tx_enable}), 32'b101);
    end
    @(negedge txclk);
    check("to1_err", 32'({busy, err, grant}), 32'b0_1_0000);

    // Second timeout with clr_err in the same cycle: err must stay set.
    req = 4'b0001;
    wait_ld(lat);
    check("to2_lat", 32'(lat), 32'd1);
    req = '0;
    repeat (3) @(negedge txclk);
    clr_err = 1'b1;
    @(negedge txclk);
    clr_err = 1'b0;
    check("to2_err_kept", 32'(err), 32'd1);
    check("to2_idle", 32'(busy), 32'd0);

    // Arbitration still works with err set.
    stuck = 1'b0;
    do_vector(vecs[1], "post_err");
    check("post_err_err", 32'(err), 32'd1);
    clr_err = 1'b1;
    @(negedge txclk);
    clr_err = 1'b0;
    check("clr_err", 32'(err), 32'd0);

    // Reset during WAIT_DONE.
    req_data = 32'h0077_0000;
    req      = 4'b0100;
    wait_ld(lat);
    check("mid_lat", 32'(lat), 32'd1);
    req = '0;
    repeat (4) @(negedge txclk);
    check("mid_busy", 32'({busy, tx_enable}), 32'b11);
    req     = 4'b1010;
    reset_n = 1'b0;
    @(negedge txclk);
    check("mid_rst_outs", 32'({ack, grant, ld_tx_data, tx_enable, busy, err}), 32'd0);
    check("mid_rst_txdata", 32'(tx_data), 32'd0);
    reset_n = 1'b1;
    rem = '{0, 1, 0, 1};
    exp_order = '{1, 3};
    run_seq(4'b1010, "after_rst");

    // Multi-byte frame from client 1 competing with client 3.
    do_reset();
`ifdef UART_ARB_LOCK_EN
    lock = 4'b0010;
    exp_order = '{1, 1, 1, 3, 3};
`else
    exp_order = '{1, 3, 1, 3, 1};
`endif
    rem = '{0, 3, 0, 2};
    run_seq(4'b1010, "frame");

    check("proto_viol", 32'(proto_viol), 32'd0);
    check("txen_drop_viol", 32'(drop_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
